// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data memory controller.
package data_mem_ctrl_pkg;

   // Access FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2
   } state_e;

   // funct3 access size/sign encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Cycles an access may spend on the bus before it is aborted
   localparam int TIMEOUT_CYCLES_DEF = 255;

   // A halfword must sit on an even address, a word on a multiple of four
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      logic mis;
      mis = 1'b0;
      if (funct3[1:0] == F3_H[1:0]) mis = offset[0];
      else if (funct3[1:0] == F3_W[1:0]) mis = (offset != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts the addressed byte/halfword from a bus word and extends it.
module load_formatter
   import data_mem_ctrl_pkg::*;
(
   input  logic [31:0] rdata_in,
   input  logic [1:0]  offset_in,
   input  logic [2:0]  funct3_in,
   output logic [31:0] data_out
);

   logic [31:0] w_shifted;

   // Move the addressed lane down to bit 0, then sign- or zero-extend
   always_comb begin
      w_shifted = rdata_in >> {offset_in, 3'b000};
      case (funct3_in)
         F3_B:    data_out = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_BU:   data_out = {24'h0, w_shifted[7:0]};
         F3_H:    data_out = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_HU:   data_out = {16'h0, w_shifted[15:0]};
         default: data_out = w_shifted;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: turns pipeline load/store requests into
// single-beat bus transactions with alignment checks and a timeout.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        wr_req_in,
   input  logic        rd_req_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   input  logic [3:0]  wmask_in,
   input  logic [2:0]  funct3_in,
   output logic        stall_out,
   output logic [31:0] rdata_out,
   output logic        rdata_valid_out,
   output logic        misalign_out,
   output logic        err_out,
   output logic        bus_req_out,
   output logic        bus_we_out,
   output logic [31:0] bus_addr_out,
   output logic [31:0] bus_wdata_out,
   output logic [3:0]  bus_be_out,
   input  logic        bus_gnt_in,
   input  logic        bus_rvalid_in,
   input  logic [31:0] bus_rdata_in
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   state_e            r_state;
   state_e            w_next_state;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_be;
   logic [2:0]        r_funct3;
   logic              r_we;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_req_any;
   logic              w_misaligned;
   logic              w_accept;
   logic              w_timeout;
   logic [31:0]       w_fmt_data;

   assign w_req_any    = wr_req_in | rd_req_in;
   assign w_misaligned = is_misaligned(funct3_in, addr_in[1:0]);
   assign w_accept     = (r_state == IDLE) & w_req_any & ~w_misaligned;
   assign w_timeout    = (r_state != IDLE) & (r_cnt == CNT_W'(TIMEOUT_CYCLES));

   // State register; reset returns to IDLE even in the middle of an access
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!rst_n_in) r_state <= IDLE;
      else           r_state <= w_next_state;
   end

   // Next-state and per-cycle control outputs
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a
      // signal unassigned and infers a latch.
      w_next_state    = r_state;
      stall_out       = 1'b0;
      bus_req_out     = 1'b0;
      bus_we_out      = 1'b0;
      rdata_valid_out = 1'b0;
      misalign_out    = 1'b0;
      err_out         = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req_any) begin
               if (w_misaligned) begin
                  misalign_out = 1'b1;
               end else begin
                  stall_out    = 1'b1;
                  w_next_state = REQ;
               end
            end
         end
         REQ: begin
            if (w_timeout) begin
               err_out      = 1'b1;
               w_next_state = IDLE;
            end else begin
               bus_req_out = 1'b1;
               bus_we_out  = r_we;
               if (bus_gnt_in && r_we) begin
                  w_next_state = IDLE;
               end else begin
                  stall_out = 1'b1;
                  if (bus_gnt_in) w_next_state = WAIT_R;
               end
            end
         end
         WAIT_R: begin
            if (w_timeout) begin
               err_out      = 1'b1;
               w_next_state = IDLE;
            end else if (bus_rvalid_in) begin
               rdata_valid_out = 1'b1;
               w_next_state    = IDLE;
            end else begin
               stall_out = 1'b1;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Capture the accepted request with store data and mask already lane-steered
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_be     <= '0;
         r_funct3 <= '0;
         r_we     <= 1'b0;
      end else if (w_accept) begin
         r_addr   <= addr_in;
         r_wdata  <= wdata_in << {addr_in[1:0], 3'b000};
         r_be     <= wmask_in << addr_in[1:0];
         r_funct3 <= funct3_in;
         r_we     <= wr_req_in;
      end
   end

   // Count cycles spent on the bus; cleared whenever IDLE is next
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)                  r_cnt <= '0;
      else if (w_next_state == IDLE)  r_cnt <= '0;
      else if (r_state != IDLE)       r_cnt <= r_cnt + CNT_W'(1);
   end

   assign bus_addr_out  = {r_addr[31:2], 2'b00};
   assign bus_wdata_out = r_wdata;
   assign bus_be_out    = r_be;

   load_formatter u_load_formatter (
      .rdata_in  (bus_rdata_in),
      .offset_in (r_addr[1:0]),
      .funct3_in (r_funct3),
      .data_out  (w_fmt_data)
   );

   assign rdata_out = rdata_valid_out ? w_fmt_data : 32'h0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, reset
// corner cases and randomized accesses against a behavioural model.
module tb_data_mem_ctrl;
   import data_mem_ctrl_pkg::*;

   localparam int TO = 4;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        wr_req_in, rd_req_in;
   logic [31:0] addr_in, wdata_in;
   logic [3:0]  wmask_in;
   logic [2:0]  funct3_in;
   logic        stall_out;
   logic [31:0] rdata_out;
   logic        rdata_valid_out, misalign_out, err_out;
   logic        bus_req_out, bus_we_out;
   logic [31:0] bus_addr_out, bus_wdata_out;
   logic [3:0]  bus_be_out;
   logic        bus_gnt_in, bus_rvalid_in;
   logic [31:0] bus_rdata_in;

   always #5 clk_in = ~clk_in;

   data_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .wr_req_in       (wr_req_in),
      .rd_req_in       (rd_req_in),
      .addr_in         (addr_in),
      .wdata_in        (wdata_in),
      .wmask_in        (wmask_in),
      .funct3_in       (funct3_in),
      .stall_out       (stall_out),
      .rdata_out       (rdata_out),
      .rdata_valid_out (rdata_valid_out),
      .misalign_out    (misalign_out),
      .err_out         (err_out),
      .bus_req_out     (bus_req_out),
      .bus_we_out      (bus_we_out),
      .bus_addr_out    (bus_addr_out),
      .bus_wdata_out   (bus_wdata_out),
      .bus_be_out      (bus_be_out),
      .bus_gnt_in      (bus_gnt_in),
      .bus_rvalid_in   (bus_rvalid_in),
      .bus_rdata_in    (bus_rdata_in)
   );

   int n_checks = 0;
   int n_errors = 0;

   // One access: stimulus, bus response timing and expected results.
   // g = REQ cycle index carrying the grant, r = WAIT_R cycle index carrying rvalid.
   typedef struct {
      logic        we, rd;
      logic [31:0] addr, wdata;
      logic [3:0]  mask;
      logic [2:0]  f3;
      int          g, r;
      logic [31:0] brdata;
      logic        exp_mis, exp_err;
      int          exp_stall;
      logic [31:0] exp_addr, exp_wdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, rd, input logic [31:0] addr, wdata,
                               input logic [3:0] mask, input logic [2:0] f3,
                               input int g, r, input logic [31:0] brdata,
                               input logic exp_mis, exp_err, input int exp_stall,
                               input logic [31:0] exp_addr, exp_wdata,
                               input logic [3:0] exp_be, input logic [31:0] exp_rdata);
      vec_t v;
      v.we = we; v.rd = rd; v.addr = addr; v.wdata = wdata; v.mask = mask; v.f3 = f3;
      v.g = g; v.r = r; v.brdata = brdata;
      v.exp_mis = exp_mis; v.exp_err = exp_err; v.exp_stall = exp_stall;
      v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_be = exp_be;
      v.exp_rdata = exp_rdata;
      return v;
   endfunction

   // Reference load result: pick the byte/halfword at the offset, extend it
   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3);
      logic [31:0] sh;
      sh = word >> (8 * off);
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'h0, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return word;
      endcase
   endfunction

   // Behavioural model: derive every expectation of an access from its inputs
   function automatic vec_t ref_vec(input logic we, rd, input logic [31:0] addr, wdata,
                                    input logic [3:0] mask, input logic [2:0] f3,
                                    input int g, r, input logic [31:0] brdata);
      vec_t v;
      int size, done;
      logic [7:0] wide_be;
      v = mk(we, rd, addr, wdata, mask, f3, g, r, brdata, 0, 0, 0, 0, 0, 0, 0);
      size = 1 << f3[1:0];
      v.exp_mis   = (addr % size) != 0;
      v.exp_addr  = addr & 32'hFFFF_FFFC;
      v.exp_wdata = wdata << (8 * addr[1:0]);
      wide_be     = {4'b0, mask} << addr[1:0];
      v.exp_be    = wide_be[3:0];
      v.exp_rdata = we ? 32'h0 : ref_load(brdata, addr[1:0], f3);
      if (!v.exp_mis) begin
         done        = we ? g : g + 1 + r;
         v.exp_err   = done >= TO;
         v.exp_stall = v.exp_err ? TO + 1 : done + 1;
         if (v.exp_err) v.exp_rdata = 32'h0;
      end
      return v;
   endfunction

   // Runs one access. Entered and left at 1 time unit after a rising edge.
   task automatic run_txn(input string tag, input vec_t v, input bit junk);
      int          stall_seen;
      logic        err_seen, mis_seen;
      int          done_k;
      logic [5:0]  exp_f;
      logic [31:0] exp_rd;
      stall_seen = 0; err_seen = 0; mis_seen = 0;
      wr_req_in = v.we; rd_req_in = v.rd; addr_in = v.addr; wdata_in = v.wdata;
      wmask_in = v.mask; funct3_in = v.f3; bus_gnt_in = 1'b0;
      bus_rvalid_in = junk ? 1'($urandom) : 1'b0;
      bus_rdata_in = $urandom;
      @(negedge clk_in);
      if (stall_out) stall_seen++;
      err_seen |= err_out; mis_seen |= misalign_out;
      exp_f = v.exp_mis ? 6'b000001 : 6'b100000;
      check({tag, " accept flags"},
            {stall_out, bus_req_out, bus_we_out, rdata_valid_out, err_out, misalign_out}, exp_f);
      check({tag, " accept rdata"}, rdata_out, 32'h0);
      @(posedge clk_in); #1;
      wr_req_in = 1'b0; rd_req_in = 1'b0;
      if (v.exp_mis) begin
         @(negedge clk_in);
         check({tag, " after misalign flags"},
               {stall_out, bus_req_out, bus_we_out, rdata_valid_out, err_out, misalign_out}, 6'b0);
         @(posedge clk_in); #1;
      end else begin
         done_k = v.we ? v.g : v.g + 1 + v.r;
         for (int k = 0; k <= TO; k++) begin
            bus_gnt_in = (k == v.g);
            if (!v.we && k == done_k) begin
               bus_rvalid_in = 1'b1;
               bus_rdata_in  = v.brdata;
            end else begin
               bus_rvalid_in = (junk && k <= v.g) ? 1'($urandom) : 1'b0;
               bus_rdata_in  = $urandom;
            end
            @(negedge clk_in);
            if (stall_out) stall_seen++;
            err_seen |= err_out; mis_seen |= misalign_out;
            exp_rd = 32'h0;
            if (k == TO)          exp_f = 6'b000010;
            else if (k < v.g)     exp_f = {2'b11, v.we, 3'b000};
            else if (k == v.g)    exp_f = {~v.we, 1'b1, v.we, 3'b000};
            else if (k < done_k)  exp_f = 6'b100000;
            else begin
               exp_f  = 6'b000100;
               exp_rd = v.exp_rdata;
            end
            check($sformatf("%s k%0d flags", tag, k),
                  {stall_out, bus_req_out, bus_we_out, rdata_valid_out, err_out, misalign_out}, exp_f);
            check($sformatf("%s k%0d rdata", tag, k), rdata_out, exp_rd);
            if (k <= v.g && k < TO) begin
               check($sformatf("%s k%0d bus_addr", tag, k), bus_addr_out, v.exp_addr);
               if (v.we) begin
                  check($sformatf("%s k%0d bus_wdata", tag, k), bus_wdata_out, v.exp_wdata);
                  check($sformatf("%s k%0d bus_be", tag, k), {28'h0, bus_be_out}, {28'h0, v.exp_be});
               end
            end
            @(posedge clk_in); #1;
            if (k == TO || k == done_k) break;
         end
      end
      bus_gnt_in = 1'b0; bus_rvalid_in = 1'b0;
      check({tag, " stall cycles"}, stall_seen, v.exp_stall);
      check({tag, " err seen"}, {31'h0, err_seen}, {31'h0, v.exp_err});
      check({tag, " misalign seen"}, {31'h0, mis_seen}, {31'h0, v.exp_mis});
   endtask

   initial begin
      vec_t        v;
      logic [2:0]  f3_list[5];
      logic        we, rd;
      logic [2:0]  f3;
      f3_list = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

      //        we rd addr          wdata          mask     f3     g  r   brdata         mis err st exp_addr      exp_wdata      be       exp_rdata
      vecs.push_back(mk(1, 0, 32'h1003, 32'h000000AB, 4'b0001, F3_B,  0, 0,  32'h0,        0, 0, 1, 32'h1000, 32'hAB000000, 4'b1000, 32'h0));
      vecs.push_back(mk(0, 1, 32'h2002, 32'h0,        4'b0000, F3_H,  0, 0,  32'h80010000, 0, 0, 2, 32'h2000, 32'h0,        4'b0000, 32'hFFFF8001));
      vecs.push_back(mk(0, 1, 32'h2002, 32'h0,        4'b0000, F3_HU, 0, 0,  32'h80010000, 0, 0, 2, 32'h2000, 32'h0,        4'b0000, 32'h00008001));
      vecs.push_back(mk(0, 1, 32'h3001, 32'h0,        4'b0000, F3_W,  0, 0,  32'h0,        1, 0, 0, 32'h0,    32'h0,        4'b0000, 32'h0));
      vecs.push_back(mk(0, 1, 32'h5000, 32'h0,        4'b0000, F3_W,  0, 99, 32'h0,        0, 1, 5, 32'h5000, 32'h0,        4'b0000, 32'h0));
      vecs.push_back(mk(1, 1, 32'h4000, 32'h12345678, 4'b1111, F3_W,  1, 0,  32'h0,        0, 0, 2, 32'h4000, 32'h12345678, 4'b1111, 32'h0));
      vecs.push_back(mk(0, 1, 32'h6001, 32'h0,        4'b0000, F3_B,  1, 1,  32'h00008000, 0, 0, 4, 32'h6000, 32'h0,        4'b0000, 32'hFFFFFF80));
      vecs.push_back(mk(0, 1, 32'h6003, 32'h0,        4'b0000, F3_BU, 0, 0,  32'hFE000000, 0, 0, 2, 32'h6000, 32'h0,        4'b0000, 32'h000000FE));
      vecs.push_back(mk(1, 0, 32'h7002, 32'h0000BEEF, 4'b0011, F3_H,  0, 0,  32'h0,        0, 0, 1, 32'h7000, 32'hBEEF0000, 4'b1100, 32'h0));
      vecs.push_back(mk(1, 0, 32'h7001, 32'h0000BEEF, 4'b0011, F3_H,  0, 0,  32'h0,        1, 0, 0, 32'h0,    32'h0,        4'b0000, 32'h0));
      vecs.push_back(mk(0, 1, 32'h8000, 32'h0,        4'b0000, F3_W,  4, 0,  32'h0,        0, 1, 5, 32'h8000, 32'h0,        4'b0000, 32'h0));
      vecs.push_back(mk(0, 1, 32'h8004, 32'h0,        4'b0000, F3_W,  0, 2,  32'hCAFEF00D, 0, 0, 4, 32'h8004, 32'h0,        4'b0000, 32'hCAFEF00D));
      vecs.push_back(mk(1, 0, 32'hA008, 32'hDEADBEEF, 4'b1111, F3_W,  3, 0,  32'h0,        0, 0, 4, 32'hA008, 32'hDEADBEEF, 4'b1111, 32'h0));
      vecs.push_back(mk(0, 1, 32'hB000, 32'h0,        4'b0000, F3_W,  0, 3,  32'h11111111, 0, 1, 5, 32'hB000, 32'h0,        4'b0000, 32'h0));
      vecs.push_back(mk(1, 0, 32'hC002, 32'h00000012, 4'b0011, F3_B,  0, 0,  32'h0,        0, 0, 1, 32'hC000, 32'h00120000, 4'b1100, 32'h0));
      vecs.push_back(mk(1, 0, 32'hC003, 32'h11223344, 4'b1111, F3_B,  0, 0,  32'h0,        0, 0, 1, 32'hC000, 32'h44000000, 4'b1000, 32'h0));

      rst_n_in = 1'b0;
      wr_req_in = 1'b0; rd_req_in = 1'b0; addr_in = '0; wdata_in = '0; wmask_in = '0;
      funct3_in = '0; bus_gnt_in = 1'b0; bus_rvalid_in = 1'b0; bus_rdata_in = '0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      check("reset flags",
            {stall_out, bus_req_out, bus_we_out, rdata_valid_out, err_out, misalign_out}, 6'b0);
      check("reset rdata", rdata_out, 32'h0);
      check("reset bus_addr", bus_addr_out, 32'h0);
      check("reset bus_wdata", bus_wdata_out, 32'h0);
      check("reset bus_be", {28'h0, bus_be_out}, 32'h0);
      @(posedge clk_in); #1;
      rst_n_in = 1'b1;

      // Directed table, issued back to back
      for (int i = 0; i < vecs.size(); i++) run_txn($sformatf("vec%0d", i), vecs[i], 1'b0);

      // Reset while a read waits for its data
      rd_req_in = 1'b1; funct3_in = F3_W; addr_in = 32'h9000;
      @(posedge clk_in); #1;
      rd_req_in = 1'b0; bus_gnt_in = 1'b1;
      @(posedge clk_in); #1;
      bus_gnt_in = 1'b0;
      @(negedge clk_in);
      check("wait_r stall before reset", {31'h0, stall_out}, 32'h1);
      #1 rst_n_in = 1'b0;
      #1;
      check("mid-access reset bus_req", {31'h0, bus_req_out}, 32'h0);
      check("mid-access reset stall", {31'h0, stall_out}, 32'h0);
      check("mid-access reset bus_addr", bus_addr_out, 32'h0);
      @(posedge clk_in); #1;
      rst_n_in = 1'b1;
      run_txn("post-reset LW", ref_vec(1'b0, 1'b1, 32'h9004, 32'h0, 4'h0, F3_W, 0, 0, 32'h13572468), 1'b0);

      // Randomized accesses against the model
      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom);
         rd = we ? 1'($urandom) : 1'b1;
         f3 = we ? f3_list[$urandom_range(0, 2)] : f3_list[$urandom_range(0, 4)];
         v  = ref_vec(we, rd, $urandom, $urandom, 4'($urandom), f3,
                      $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
         run_txn($sformatf("rnd%0d", i), v, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
